// File: rtl/traffic_pkg.sv
// Shared encodings and helpers for the multi-channel packet injector.
// Holds destination modes, the LFSR polynomial and the per-channel FSM states.
package traffic_pkg;

  localparam int MODE_FIXED  = 0;
  localparam int MODE_RANDOM = 1;
  localparam int MODE_RR     = 2;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Head marker bit, counted down from the flit MSB.
  localparam int HEAD_BIT_FROM_MSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } ch_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  // An all-zero Galois LFSR never leaves zero, so force a nonzero seed.
  function automatic logic [15:0] lfsr_seed(input int seed);
    logic [15:0] s;
    s = seed[15:0];
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/traffic_source_channel.sv
// One packet source: head/body FSM, destination generator (fixed, LFSR or
// round-robin), inter-packet gap counter and completed-packet counter.
module traffic_source_channel
  import traffic_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int DEST_BITS  = 7,
  parameter int FLITS      = 8,
  parameter int MODE       = 1,
  parameter int FIXED_DEST = 0,
  parameter int GAP        = 0,
  parameter int SEED_VAL   = 5,
  parameter int CNT_BITS   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                ack_i,
  output logic                req_o,
  output logic [SIZE-1:0]     data_o,
  output logic [CNT_BITS-1:0] count_o
);

  localparam int SEQ_W = $clog2(FLITS);
  localparam int GAP_W = $clog2(GAP + 2);
  localparam logic [SEQ_W-1:0]     SEQ_LAST = SEQ_W'(FLITS - 1);
  localparam logic [DEST_BITS-1:0] FIXED_D  = DEST_BITS'(FIXED_DEST);
  localparam logic [15:0]          SEED_Q   = lfsr_seed(SEED_VAL);

  ch_state_e            state_q, state_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [DEST_BITS-1:0] rr_q, rr_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]      data_q, data_d;

  logic                 xfer, last;
  logic [DEST_BITS-1:0] dest;

  function automatic logic [SIZE-1:0] mk_flit(input logic head,
                                              input logic [DEST_BITS-1:0] f);
    logic [SIZE-1:0] r;
    r = '0;
    r[SIZE-1-HEAD_BIT_FROM_MSB] = head;
    r[DEST_BITS-1:0] = f;
    return r;
  endfunction

  assign xfer = (state_q != ST_IDLE) && ack_i;
  assign last = (seq_q == SEQ_LAST);

  always_comb begin
    dest = FIXED_D;
    if (MODE == MODE_RANDOM) dest = lfsr_q[DEST_BITS-1:0];
    else if (MODE == MODE_RR) dest = rr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (gap_q == '0 && en_i) state_d = ST_HEAD;
      ST_HEAD: if (xfer) state_d = ST_BODY;
      ST_BODY: if (xfer && last) state_d = (GAP == 0 && en_i) ? ST_HEAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state; the head flit is built on the cycle HEAD is entered
  // so the destination is frozen for the whole time tx_req waits on ack.
  always_comb begin
    seq_d  = seq_q;
    gap_d  = gap_q;
    lfsr_d = lfsr_q;
    rr_d   = rr_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        if (state_d == ST_HEAD) data_d = mk_flit(1'b1, dest);
      end
      ST_HEAD: begin
        if (xfer) begin
          seq_d  = SEQ_W'(1);
          data_d = mk_flit(1'b0, DEST_BITS'(1));
          lfsr_d = lfsr_step(lfsr_q);
          rr_d   = rr_q + 1'b1;
        end
      end
      ST_BODY: begin
        if (xfer && !last) begin
          seq_d  = seq_q + 1'b1;
          data_d = mk_flit(1'b0, DEST_BITS'(seq_q + 1'b1));
        end else if (xfer) begin
          seq_d = '0;
          cnt_d = cnt_q + 1'b1;
          if (state_d == ST_HEAD) begin
            data_d = mk_flit(1'b1, dest);
          end else begin
            data_d = '0;
            gap_d  = GAP_W'(GAP);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      seq_q  <= '0;
      gap_q  <= '0;
      lfsr_q <= SEED_Q;
      rr_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      seq_q  <= seq_d;
      gap_q  <= gap_d;
      lfsr_q <= lfsr_d;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    req_o   = (state_q != ST_IDLE);
    data_o  = data_q;
    count_o = cnt_q;
  end

endmodule

// File: rtl/traffic_source.sv
// CHANNELS independent packet sources over the req/ack link, one per router
// rx port; this level only checks parameters and slices the flat buses.
module traffic_source
  import traffic_pkg::*;
#(
  parameter int CHANNELS   = 5,
  parameter int SIZE       = 8,
  parameter int DEST_BITS  = SIZE - 1,
  parameter int FLITS      = 8,
  parameter int MODE       = 1,
  parameter int FIXED_DEST = 0,
  parameter int GAP        = 0,
  parameter int SEED       = 5,
  parameter int CNT_BITS   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          en,
  output logic [CHANNELS-1:0]          tx_req,
  input  logic [CHANNELS-1:0]          tx_ack,
  output logic [SIZE*CHANNELS-1:0]     tx_data,
  output logic [CNT_BITS*CHANNELS-1:0] pkt_count
);

  if (DEST_BITS >= SIZE) begin : g_err_dest_size
    $error("traffic_source: DEST_BITS must be less than SIZE");
  end
  if (DEST_BITS > 16) begin : g_err_dest_wide
    $error("traffic_source: DEST_BITS must not exceed 16");
  end
  if (FLITS < 2) begin : g_err_flits
    $error("traffic_source: FLITS must be at least 2");
  end
  if (MODE < MODE_FIXED || MODE > MODE_RR) begin : g_err_mode
    $error("traffic_source: unknown MODE");
  end

  logic [CHANNELS-1:0][SIZE-1:0]     data_w;
  logic [CHANNELS-1:0][CNT_BITS-1:0] cnt_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    traffic_source_channel #(
      .SIZE       (SIZE),
      .DEST_BITS  (DEST_BITS),
      .FLITS      (FLITS),
      .MODE       (MODE),
      .FIXED_DEST (FIXED_DEST),
      .GAP        (GAP),
      .SEED_VAL   (SEED + i),
      .CNT_BITS   (CNT_BITS)
    ) u_ch (
      .clk_i   (clk),
      .rst_ni  (reset),
      .en_i    (en[i]),
      .ack_i   (tx_ack[i]),
      .req_o   (tx_req[i]),
      .data_o  (data_w[i]),
      .count_o (cnt_w[i])
    );
  end

  assign tx_data   = data_w;
  assign pkt_count = cnt_w;

endmodule

// File: tb/tb_traffic_source.sv
// Three configurations (fixed / round-robin+gap / LFSR+small counter) checked
// every cycle against a packet-level model, plus hand-computed literals.
module tb_traffic_source;

  localparam int NCH [3] = '{5, 3, 3};
  localparam int SZ  [3] = '{8, 3, 8};
  localparam int DB  [3] = '{7, 2, 7};
  localparam int FL  [3] = '{4, 3, 5};
  localparam int MD  [3] = '{0, 2, 1};
  localparam int FX  [3] = '{3, 0, 0};
  localparam int GP  [3] = '{0, 3, 1};
  localparam int SD  [3] = '{5, 5, 0};
  localparam int CB  [3] = '{16, 16, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] en0 = '0, ack0 = '0, req0;
  logic [39:0] dat0;
  logic [79:0] cnt0;
  logic [2:0] en1 = '0, ack1 = '0, req1;
  logic [8:0] dat1;
  logic [47:0] cnt1;
  logic [2:0] en2 = '0, ack2 = '0, req2;
  logic [23:0] dat2;
  logic [8:0] cnt2;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // packet-level model: offering flag, flit index, packets done, heads sent,
  // LFSR value, and the first edge at which a new head may be started
  int m_on [3][5];
  int m_fi [3][5];
  int m_pk [3][5];
  int m_hd [3][5];
  int m_rdy[3][5];
  logic [15:0] m_lf[3][5];

  traffic_source #(.CHANNELS(5), .SIZE(8), .DEST_BITS(7), .FLITS(4), .MODE(0),
    .FIXED_DEST(3), .GAP(0), .SEED(5), .CNT_BITS(16)) u_d0 (
    .clk(clk), .reset(rst_n), .en(en0), .tx_req(req0), .tx_ack(ack0),
    .tx_data(dat0), .pkt_count(cnt0));
  traffic_source #(.CHANNELS(3), .SIZE(3), .DEST_BITS(2), .FLITS(3), .MODE(2),
    .FIXED_DEST(0), .GAP(3), .SEED(5), .CNT_BITS(16)) u_d1 (
    .clk(clk), .reset(rst_n), .en(en1), .tx_req(req1), .tx_ack(ack1),
    .tx_data(dat1), .pkt_count(cnt1));
  traffic_source #(.CHANNELS(3), .SIZE(8), .DEST_BITS(7), .FLITS(5), .MODE(1),
    .FIXED_DEST(0), .GAP(1), .SEED(0), .CNT_BITS(3)) u_d2 (
    .clk(clk), .reset(rst_n), .en(en2), .tx_req(req2), .tx_ack(ack2),
    .tx_data(dat2), .pkt_count(cnt2));

  always #5 clk = ~clk;

  function automatic int o_req(int d, int c);
    case (d)
      0: return int'(req0[c]);
      1: return int'(req1[c]);
      default: return int'(req2[c]);
    endcase
  endfunction
  function automatic int o_dat(int d, int c);
    case (d)
      0: return int'(dat0[c*8 +: 8]);
      1: return int'(dat1[c*3 +: 3]);
      default: return int'(dat2[c*8 +: 8]);
    endcase
  endfunction
  function automatic int o_cnt(int d, int c);
    case (d)
      0: return int'(cnt0[c*16 +: 16]);
      1: return int'(cnt1[c*16 +: 16]);
      default: return int'(cnt2[c*3 +: 3]);
    endcase
  endfunction
  function automatic bit i_en(int d, int c);
    case (d)
      0: return en0[c];
      1: return en1[c];
      default: return en2[c];
    endcase
  endfunction
  function automatic bit i_ack(int d, int c);
    case (d)
      0: return ack0[c];
      1: return ack1[c];
      default: return ack2[c];
    endcase
  endfunction
  task automatic set_in(int d, int c, bit e, bit a);
    case (d)
      0: begin en0[c] = e; ack0[c] = a; end
      1: begin en1[c] = e; ack1[c] = a; end
      default: begin en2[c] = e; ack2[c] = a; end
    endcase
  endtask
  task automatic set_all(bit e, bit a);
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < NCH[d]; c++) set_in(d, c, e, a);
  endtask

  function automatic logic [15:0] gal(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction
  function automatic logic [15:0] seed_of(int s);
    int v;
    v = s % 65536;
    return (v == 0) ? 16'h0001 : 16'(v);
  endfunction

  function automatic int exp_flit(int d, int c);
    int dmask, dest;
    dmask = (1 << DB[d]) - 1;
    if (m_fi[d][c] != 0) return m_fi[d][c] & dmask;
    case (MD[d])
      0: dest = FX[d];
      1: dest = int'(m_lf[d][c]);
      default: dest = m_hd[d][c];
    endcase
    return (1 << (SZ[d] - 1)) | (dest & dmask);
  endfunction

  task automatic chk(string nm, int d, int c, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s d%0d ch%0d edge %0d: got %0h expected %0h", nm, d, c, edge_n, act, exp);
    end
  endtask

  task automatic model_advance();
    int e;
    e = edge_n + 1;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < NCH[d]; c++) begin
        if (!rst_n) begin
          m_on[d][c] = 0; m_fi[d][c] = 0; m_pk[d][c] = 0; m_hd[d][c] = 0;
          m_lf[d][c] = seed_of(SD[d] + c);
          m_rdy[d][c] = e + 1;
        end else if (m_on[d][c] != 0) begin
          if (i_ack(d, c)) begin
            if (m_fi[d][c] == 0) begin
              m_hd[d][c]++;
              m_lf[d][c] = gal(m_lf[d][c]);
              m_fi[d][c] = 1;
            end else if (m_fi[d][c] == FL[d] - 1) begin
              m_pk[d][c]++;
              m_fi[d][c] = 0;
              if (!(GP[d] == 0 && i_en(d, c))) begin
                m_on[d][c] = 0;
                m_rdy[d][c] = e + GP[d] + 1;
              end
            end else begin
              m_fi[d][c]++;
            end
          end
        end else if (e >= m_rdy[d][c] && i_en(d, c)) begin
          m_on[d][c] = 1;
        end
      end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < NCH[d]; c++) begin
        chk("req", d, c, o_req(d, c), m_on[d][c]);
        if (m_on[d][c] != 0) chk("data", d, c, o_dat(d, c), exp_flit(d, c));
        chk("count", d, c, o_cnt(d, c), m_pk[d][c] & ((1 << CB[d]) - 1));
      end
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    edge_n++;
    #1;
    compare_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q0[$], h1[$], h1e[$], h20[$], h22[$];
    int held, n, cnt_chk_at;
    bit found;

    // reset
    set_all(1'b0, 1'b0);
    rst_n = 1'b0;
    step(); step();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < NCH[d]; c++) begin
        chk("rst_req", d, c, o_req(d, c), 0);
        chk("rst_data", d, c, o_dat(d, c), 0);
        chk("rst_count", d, c, o_cnt(d, c), 0);
      end
    rst_n = 1'b1;

    // continuous streaming, ack tied high
    set_all(1'b1, 1'b1);
    cnt_chk_at = -1;
    for (int s = 0; s < 40; s++) begin
      step();
      if (s == cnt_chk_at) chk("cnt_after_8", 0, 0, o_cnt(0, 0), 2);
      if (o_req(0, 0) == 1 && q0.size() < 8) begin
        q0.push_back(o_dat(0, 0));
        if (q0.size() == 8) cnt_chk_at = s + 1;
      end
      if (o_req(1, 0) == 1 && ((o_dat(1, 0) >> 2) & 1) == 1) begin
        h1.push_back(o_dat(1, 0));
        h1e.push_back(edge_n);
      end
      if (o_req(2, 0) == 1 && ((o_dat(2, 0) >> 7) & 1) == 1) h20.push_back(o_dat(2, 0));
      if (o_req(2, 2) == 1 && ((o_dat(2, 2) >> 7) & 1) == 1) h22.push_back(o_dat(2, 2));
    end
    begin
      int exp0[8] = '{'h83, 'h01, 'h02, 'h03, 'h83, 'h01, 'h02, 'h03};
      int exp1[5] = '{4, 5, 6, 7, 4};
      chk("stream_len", 0, 0, q0.size(), 8);
      for (int i = 0; i < 8 && i < q0.size(); i++) chk("stream_flit", 0, 0, q0[i], exp0[i]);
      chk("rr_heads", 1, 0, h1.size() >= 5 ? 1 : 0, 1);
      for (int i = 0; i < 5 && i < h1.size(); i++) chk("rr_head", 1, 0, h1[i], exp1[i]);
      if (h1e.size() >= 2) chk("gap_spacing", 1, 0, h1e[1] - h1e[0], 7);
      else chk("gap_spacing", 1, 0, h1e.size(), 2);
      chk("lfsr_heads0", 2, 0, h20.size() >= 2 ? 1 : 0, 1);
      if (h20.size() >= 2) begin
        chk("lfsr_head", 2, 0, h20[0], 'h81);
        chk("lfsr_head", 2, 0, h20[1], 'h80);
      end
      chk("lfsr_heads2", 2, 2, h22.size() >= 2 ? 1 : 0, 1);
      if (h22.size() >= 2) begin
        chk("lfsr_head", 2, 2, h22[0], 'h82);
        chk("lfsr_head", 2, 2, h22[1], 'h81);
      end
    end

    // backpressure in the body of d0 ch0
    found = 1'b0;
    for (int s = 0; s < 10 && !found; s++) begin
      if (m_fi[0][0] == 2) found = 1'b1;
      else step();
    end
    chk("bp_reach_body", 0, 0, int'(found), 1);
    held = o_dat(0, 0);
    chk("bp_held", 0, 0, held, 'h02);
    set_in(0, 0, 1'b1, 1'b0);
    for (int s = 0; s < 5; s++) begin
      step();
      chk("bp_req", 0, 0, o_req(0, 0), 1);
      chk("bp_data", 0, 0, o_dat(0, 0), held);
    end
    set_in(0, 0, 1'b1, 1'b1);
    step();
    chk("bp_release", 0, 0, o_dat(0, 0), 'h03);

    // en dropped on d1 ch1: packet completes, channel then stays idle
    set_in(1, 1, 1'b0, 1'b1);
    n = 0;
    while (m_on[1][1] != 0 && n < 30) begin step(); n++; end
    chk("en_drop_idle", 1, 1, m_on[1][1], 0);
    for (int s = 0; s < 10; s++) begin
      step();
      chk("en_low_req", 1, 1, o_req(1, 1), 0);
    end
    set_in(1, 1, 1'b1, 1'b1);
    step();
    chk("en_restart_req", 1, 1, o_req(1, 1), 1);
    chk("en_restart_head", 1, 1, (o_dat(1, 1) >> 2) & 1, 1);

    // randomized traffic
    for (int s = 0; s < 1500; s++) begin
      for (int d = 0; d < 3; d++)
        for (int c = 0; c < NCH[d]; c++)
          set_in(d, c, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0);
      step();
    end

    // reset while d0 ch2 is mid-body
    set_all(1'b1, 1'b1);
    n = 0;
    while (m_fi[0][2] == 0 && n < 12) begin step(); n++; end
    chk("rst_mid_body", 0, 2, m_fi[0][2] != 0 ? 1 : 0, 1);
    rst_n = 1'b0;
    step();
    chk("rst2_req", 0, 2, o_req(0, 2), 0);
    chk("rst2_count", 0, 2, o_cnt(0, 2), 0);
    chk("rst2_req", 2, 2, o_req(2, 2), 0);
    chk("rst2_count", 2, 2, o_cnt(2, 2), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) set_in(2, c, 1'b1, 1'b0);
    step();
    chk("reseed_req", 2, 2, o_req(2, 2), 1);
    chk("reseed_head", 2, 2, o_dat(2, 2), 'h82);
    set_all(1'b1, 1'b1);
    for (int s = 0; s < 20; s++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_source.md
# traffic_source

Parametrised multi-channel packet injector driving the router's receive channels over the req/ack link protocol. It generalises the single-channel packet source to CHANNELS independent sources. Each source adds selectable destination modes, configurable packet length, a configurable inter-packet gap, a per-channel enable and a per-channel packet counter. It sits on the bench/traffic side of the router and connects one channel per router rx port.

## Interface
- CHANNELS, 5, number of independent source channels
- SIZE, 8, flit width in bits
- DEST_BITS, SIZE-1, destination field width; must be ≤ 16 and < SIZE
- FLITS, 8, flits per packet including head; must be ≥ 2
- MODE, 1, destination mode: 0 fixed, 1 uniform random, 2 round-robin
- FIXED_DEST, 0, destination used in mode 0 (all channels)
- GAP, 0, idle cycles between a tail acceptance and the next head
- SEED, 5, LFSR seed base; channel i seeds with SEED+i
- CNT_BITS, 16, packet counter width per channel
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- en  in  CHANNELS  per-channel enable, sampled only at packet boundaries
- tx_req  out  CHANNELS  flit valid per channel
- tx_ack  in  CHANNELS  flit accepted per channel
- tx_data  out  SIZE*CHANNELS  flit per channel; channel i at [SIZE*(i+1)-1 : SIZE*i]
- pkt_count  out  CNT_BITS*CHANNELS  completed packets per channel, same slicing

## Operation
- Transfer rule: a flit transfers on a rising edge where tx_req[i] and tx_ack[i] are both 1. While tx_req is high, tx_data is held stable until the transfer. tx_req never drops without a transfer.
- Flit format: head = {1'b1, zero-pad, dest[DEST_BITS-1:0]}. Body = {1'b0, zero-pad, seq[DEST_BITS-1:0]}, where seq is the body index 1..FLITS-1. The tail is the body flit with seq = FLITS-1.
- Per-channel FSM states:
  - IDLE: tx_req=0. Go to HEAD when gap_cnt==0 and en[i]=1.
  - HEAD: tx_req=1. On transfer, go to BODY with seq=1.
  - BODY: tx_req=1. On transfer with seq<FLITS-1, increment seq. On transfer with seq=FLITS-1, count the packet:
    - GAP=0 and en[i]=1: go to HEAD.
    - Otherwise: go to IDLE and load gap_cnt=GAP.
- gap_cnt decrements once per cycle in IDLE until it reaches 0.
- Dropping en mid-packet does not truncate the packet; the current packet completes.
- Destination selection, fixed at HEAD entry:
  - Mode 0: FIXED_DEST.
  - Mode 1: lfsr[DEST_BITS-1:0].
  - Mode 2: rr register, starting at 0 after reset and incrementing modulo 2^DEST_BITS after each head transfer (wraps 2^DEST_BITS-1 → 0).
- LFSR: 16-bit Galois, mask 16'hB400, seeded with (SEED+i)[15:0]. A zero seed is forced to 16'h0001. The LFSR advances exactly once per head transfer.
- pkt_count increments on each tail transfer and wraps modulo 2^CNT_BITS.

## Timing
- Reset values: tx_req=0, tx_data=0, pkt_count=0, FSM=IDLE, gap_cnt=0, rr=0, LFSR reseeded.
- All outputs are registered. No combinational path exists from tx_ack or en to any output.
- First head: en[i]=1 sampled at edge k (reset high) gives tx_req[i]=1 and the head on tx_data after edge k.
- Next flit: a transfer at edge k puts the next flit on tx_data after edge k. With tx_ack tied high, one flit moves per cycle.
- Gap: a tail transfer at edge k with GAP=g>0 keeps tx_req=0 for g+1 cycles. The next head appears after edge k+g+1, provided en=1.
- Reset mid-packet: tx_req=0 the cycle after the reset edge. The partial packet is abandoned and not counted.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Structure
- Shared package `traffic_pkg`: mode encodings (MODE_FIXED/RANDOM/RR), LFSR mask constant, head-marker bit position.
- Sub-module `traffic_source_channel`: one FSM, LFSR, rr register and counter. The top generates CHANNELS instances and does the slicing.
- Parameter legality (DEST_BITS<SIZE, DEST_BITS≤16, FLITS≥2) is checked at elaboration.

## Test plan
- Mode 0, FIXED_DEST=3, FLITS=4, GAP=0, ack tied 1, en=1: channel 0 streams 8'h83,8'h01,8'h02,8'h03 repeatedly. pkt_count reaches 2 after 8 transfers.
- Backpressure: ack held 0 for 5 cycles during the body → tx_req stays 1 and tx_data stays constant. The flit moves exactly once when ack returns.
- Mode 2, DEST_BITS=2, SIZE=3: head destinations are 0,1,2,3,0 over five packets (wrap check).
- GAP=3: tail accepted at edge k → tx_req low on 4 cycles, head after edge k+4. With en=0 at the boundary, the channel stays idle until en=1.
- Mode 1, SEED=0: channel 0 LFSR starts at 16'h0001. Head destinations match a reference Galois 0xB400 model, advanced once per head only.
- Reset asserted mid-body on channel 2, other channels active: channel 2 returns to tx_req=0 with pkt_count=0. After release, channel 2 restarts with a head flit using its reseeded LFSR.
